// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// bsg_lru_pseudo_tree_tracker
//
// Per-set tree pseudo-LRU state for a set-associative cache, with a
// one-entry victim output buffer.
//
// This file also holds bsg_lru_pseudo_tree_decode. It turns a way index
// into a data/mask pair over the heap-ordered tree bits.
//
// Tracker ports:
//   clk_i, reset_n_i              clock, asynchronous active-low reset
//   touch_v_i/_set_i/_way_i       hit touch (always accepted)
//   victim_v_i/_set_i             victim request
//   victim_ready_o                request accepted when victim_v_i & ready
//   victim_v_o/_set_o/_way_o      held victim result
//   victim_yumi_i                 consumer takes the result (fill touch)

module bsg_lru_pseudo_tree_decode #(
  parameter int ways_p     = 8,
  parameter int lg_ways_lp = $clog2(ways_p)
) (
  input  logic [lg_ways_lp-1:0] way_id_i,
  output logic [ways_p-2:0]     data_o,
  output logic [ways_p-2:0]     mask_o
);

  // Node n sits at level floor(log2(n+1)) and has an in-level index.
  // The node lies on the way's path when the way's top level_lp bits
  // equal that index. The data bit points away from the touched half.
  for (genvar n = 0; n < ways_p-1; n++) begin : g_node
    localparam int level_lp = $clog2(n+2) - 1;
    localparam int index_lp = n + 1 - (1 << level_lp);

    logic [lg_ways_lp-1:0] prefix;

    assign prefix    = way_id_i >> (lg_ways_lp - level_lp);
    assign mask_o[n] = (prefix == lg_ways_lp'(index_lp));
    assign data_o[n] = ~way_id_i[lg_ways_lp-1-level_lp];
  end

endmodule

module bsg_lru_pseudo_tree_tracker #(
  parameter int ways_p     = 8,
  parameter int sets_p     = 16,
  parameter int lg_ways_lp = $clog2(ways_p),
  parameter int lg_sets_lp = $clog2(sets_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,

  input  logic                  touch_v_i,
  input  logic [lg_sets_lp-1:0] touch_set_i,
  input  logic [lg_ways_lp-1:0] touch_way_i,

  input  logic                  victim_v_i,
  input  logic [lg_sets_lp-1:0] victim_set_i,
  output logic                  victim_ready_o,

  output logic                  victim_v_o,
  output logic [lg_sets_lp-1:0] victim_set_o,
  output logic [lg_ways_lp-1:0] victim_way_o,
  input  logic                  victim_yumi_i
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e state_r, state_n;

  logic [ways_p-2:0]     lru_r [sets_p];
  logic [lg_sets_lp-1:0] victim_set_r;
  logic [lg_ways_lp-1:0] victim_way_r;

  logic                  accept;
  logic                  fill_v, hit_v;
  logic                  touch_in_range, held_in_range, req_in_range;
  logic [ways_p-2:0]     fill_data, fill_mask, hit_data, hit_mask;
  logic [ways_p-2:0]     fill_base, fill_val, hit_base, hit_val, bypass_tree;
  logic [ways_p-1:0]     walk_tree;
  logic [lg_ways_lp-1:0] walk_node;
  logic [lg_ways_lp-1:0] victim_way_n;

  assign victim_v_o     = (state_r == FULL);
  assign victim_set_o   = victim_set_r;
  assign victim_way_o   = victim_way_r;
  assign victim_ready_o = ~victim_v_o | victim_yumi_i;
  assign accept         = victim_v_i & victim_ready_o;

  assign touch_in_range = {1'b0, touch_set_i}  < (lg_sets_lp+1)'(sets_p);
  assign held_in_range  = {1'b0, victim_set_r} < (lg_sets_lp+1)'(sets_p);
  assign req_in_range   = {1'b0, victim_set_i} < (lg_sets_lp+1)'(sets_p);

  // A yumi on EMPTY is ignored, so the fill touch needs a held result.
  assign fill_v = victim_v_o & victim_yumi_i & held_in_range;
  assign hit_v  = touch_v_i & touch_in_range;

  bsg_lru_pseudo_tree_decode #(.ways_p(ways_p)) fill_decode (
    .way_id_i(victim_way_r),
    .data_o  (fill_data),
    .mask_o  (fill_mask)
  );

  bsg_lru_pseudo_tree_decode #(.ways_p(ways_p)) hit_decode (
    .way_id_i(touch_way_i),
    .data_o  (hit_data),
    .mask_o  (hit_mask)
  );

  // The fill touch applies first. A hit on the same set builds on the
  // filled value, so the hit wins at any node both of them touch.
  always_comb begin
    fill_base = held_in_range ? lru_r[victim_set_r] : '0;
    fill_val  = (fill_base & ~fill_mask) | (fill_data & fill_mask);

    if (fill_v && (touch_set_i == victim_set_r))
      hit_base = fill_val;
    else
      hit_base = touch_in_range ? lru_r[touch_set_i] : '0;
    hit_val = (hit_base & ~hit_mask) | (hit_data & hit_mask);

    // The requested set is read after this cycle's updates (write-first).
    if (hit_v && (victim_set_i == touch_set_i))
      bypass_tree = hit_val;
    else if (fill_v && (victim_set_i == victim_set_r))
      bypass_tree = fill_val;
    else
      bypass_tree = req_in_range ? lru_r[victim_set_i] : '0;
  end

  // Walk the tree from the root. A 0 bit goes left and a 1 bit goes right.
  // The bits taken form the way index, MSB first.
  always_comb begin
    walk_tree    = {1'b0, bypass_tree};
    walk_node    = '0;
    victim_way_n = '0;
    for (int l = 0; l < lg_ways_lp; l++) begin
      victim_way_n = (victim_way_n << 1) | lg_ways_lp'(walk_tree[walk_node]);
      walk_node    = (walk_node << 1) + lg_ways_lp'(1)
                   + lg_ways_lp'(walk_tree[walk_node]);
    end
  end

  // Tree array: the hit write comes last, so it overrides the fill write
  // when both target the same set. hit_val already includes the fill.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < sets_p; s++)
        lru_r[s] <= '0;
    end else begin
      if (fill_v)
        lru_r[victim_set_r] <= fill_val;
      if (hit_v)
        lru_r[touch_set_i] <= hit_val;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= EMPTY;
      victim_set_r <= '0;
      victim_way_r <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        victim_set_r <= victim_set_i;
        victim_way_r <= victim_way_n;
      end
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      EMPTY:   if (accept) state_n = FULL;
      FULL:    if (victim_yumi_i && !accept) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_tracker.sv
// tb_bsg_lru_pseudo_tree_tracker
//
// Scoreboard bench for bsg_lru_pseudo_tree_tracker (8 ways, 16 sets).
// A reference model of the tree bits predicts each victim when a request
// is accepted. The prediction is queued and then compared when the result
// appears on the output.

module tb_bsg_lru_pseudo_tree_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       touch_v;
  logic [3:0] touch_set;
  logic [2:0] touch_way;
  logic       victim_v_in;
  logic [3:0] victim_set_in;
  logic       victim_ready;
  logic       victim_v_out;
  logic [3:0] victim_set_out;
  logic [2:0] victim_way_out;
  logic       victim_yumi;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference tree bits per set, heap order (node n -> children 2n+1, 2n+2).
  logic [6:0] tree_m [16];
  logic [6:0] sb_q [$];
  bit         m_full;
  logic [3:0] m_set;
  logic [2:0] m_way;

  always #5 clk = ~clk;

  bsg_lru_pseudo_tree_tracker #(.ways_p(8), .sets_p(16)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .touch_v_i     (touch_v),
    .touch_set_i   (touch_set),
    .touch_way_i   (touch_way),
    .victim_v_i    (victim_v_in),
    .victim_set_i  (victim_set_in),
    .victim_ready_o(victim_ready),
    .victim_v_o    (victim_v_out),
    .victim_set_o  (victim_set_out),
    .victim_way_o  (victim_way_out),
    .victim_yumi_i (victim_yumi)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Walk the touched way's path and point each node at the other half.
  function automatic void modelTouch(input int s, input int w);
    int node;
    for (int l = 0; l < 3; l++) begin
      node = (1 << l) - 1 + (w >> (3 - l));
      tree_m[s][node] = ~((w >> (2 - l)) & 1);
    end
  endfunction

  function automatic logic [2:0] modelVictim(input int s);
    int node = 0;
    int w    = 0;
    int b;
    for (int l = 0; l < 3; l++) begin
      b    = tree_m[s][node];
      w    = (w << 1) | b;
      node = 2 * node + 1 + b;
    end
    return 3'(w);
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < 16; s++) tree_m[s] = '0;
    sb_q.delete();
    m_full = 0;
    m_set  = '0;
    m_way  = '0;
  endfunction

  // One clock cycle: drive inputs, predict, then check after the edge.
  task automatic applyStimulus(input logic tv, input logic [3:0] ts,
                               input logic [2:0] tw, input logic vv,
                               input logic [3:0] vs, input logic y);
    logic       ready_exp, accept;
    logic [6:0] e;
    touch_v       = tv;
    touch_set     = ts;
    touch_way     = tw;
    victim_v_in   = vv;
    victim_set_in = vs;
    victim_yumi   = y;
    #1;
    ready_exp = !m_full || y;
    checkOutput("ready", victim_ready, ready_exp);
    if (m_full && y) modelTouch(m_set, m_way);
    if (tv) modelTouch(ts, tw);
    accept = vv && ready_exp;
    if (accept) sb_q.push_back({vs, modelVictim(vs)});
    else if (y) m_full = 0;
    @(posedge clk);
    #1;
    if (accept) begin
      e = sb_q.pop_front();
      m_full = 1;
      m_set  = e[6:3];
      m_way  = e[2:0];
      checkOutput("result_valid", victim_v_out, 1);
      checkOutput("result_set", victim_set_out, m_set);
      checkOutput("result_way", victim_way_out, m_way);
    end else if (m_full) begin
      checkOutput("held_valid", victim_v_out, 1);
      checkOutput("held_set", victim_set_out, m_set);
      checkOutput("held_way", victim_way_out, m_way);
    end else begin
      checkOutput("idle_valid", victim_v_out, 0);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    touch_v       = 1'b0;
    touch_set     = '0;
    touch_way     = '0;
    victim_v_in   = 1'b0;
    victim_set_in = '0;
    victim_yumi   = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", victim_v_out, 0);
    checkOutput("reset_ready", victim_ready, 1);
    checkOutput("reset_way", victim_way_out, 0);
    checkOutput("reset_set", victim_set_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh set gives way 0; the buffer then stalls with ready low.
    applyStimulus(0, 0, 0, 1, 3, 0);
    checkOutput("default_way", victim_way_out, 0);
    checkOutput("default_set", victim_set_out, 3);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Same-cycle touch of way 0 seen by the request through the bypass.
    applyStimulus(1, 3, 0, 1, 3, 1);
    checkOutput("bypass_touch_way", victim_way_out, 4);
    applyStimulus(0, 0, 0, 1, 7, 1);
    checkOutput("fresh_set7_way", victim_way_out, 0);
    applyStimulus(1, 3, 4, 1, 3, 1);
    checkOutput("two_touch_way", victim_way_out, 2);

    // Auto fill with a back-to-back request on the same set.
    applyStimulus(0, 0, 0, 1, 5, 1);
    checkOutput("fresh_set5_way", victim_way_out, 0);
    applyStimulus(0, 0, 0, 1, 5, 1);
    checkOutput("autofill_b2b_way", victim_way_out, 4);

    // Stall while the held set is touched: the result must not move.
    for (int i = 0; i < 3; i++) applyStimulus(1, 5, 3'(4 + i), 0, 0, 0);
    checkOutput("stall_way", victim_way_out, 4);

    // Fill and hit in one cycle on one set: the hit must win.
    applyStimulus(0, 0, 0, 1, 9, 1);
    checkOutput("fresh_set9_way", victim_way_out, 0);
    applyStimulus(1, 9, 1, 0, 0, 1);
    applyStimulus(1, 9, 2, 0, 0, 0);
    applyStimulus(1, 9, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 9, 0);
    checkOutput("conflict_order_way", victim_way_out, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Random traffic against the reference model.
    for (int i = 0; i < 80; i++)
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    if (m_full) applyStimulus(0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1, 3, 1, 1, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", victim_v_out, 0);
    checkOutput("async_reset_ready", victim_ready, 1);
    checkOutput("async_reset_way", victim_way_out, 0);
    checkOutput("async_reset_set", victim_set_out, 0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 1, 3, 0);
    checkOutput("post_reset_cleared_way", victim_way_out, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
